usb_host_protocol_fsm: RTL and testbench

- Host-side transaction sequencer directly upstream of the USB datapath.
- Accepts single 8-byte IN (read) or OUT (write) requests from the host controller.
- Emits token, data and handshake packets into the datapath encoder and consumes decoded packets.
- Handles timeouts, NAK/corruption retries and the receive-enable window.

---
 rtl/usb_host_protocol_fsm.sv | 190 +++++++++++++++++++
 tb/tb_usb_host_protocol_fsm.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_protocol_fsm.sv
// Host-side USB transaction sequencer: sends token/data/handshake packets to the
// datapath encoder, waits for device responses and retries on NAK, corruption or timeout.
module usb_host_protocol_fsm #(
  parameter int TIMEOUT   = 256,
  parameter int MAX_RETRY = 8,
  parameter int CNT_W     = 9
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        txn_start,
  input  logic        txn_read,
  input  logic [6:0]  txn_addr,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] txn_wdata,
  output logic        busy,
  output logic        txn_done,
  output logic        txn_ok,
  output logic [63:0] txn_rdata,
  output logic [98:0] pkt_in,
  output logic        pkt_in_avail,
  input  logic        encoder_ready,
  input  logic        nrzi_avail,
  input  logic [98:0] pkt_out,
  input  logic        pkt_out_avail,
  input  logic        data_good,
  input  logic        decoder_ready,
  output logic        re
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum logic [2:0] {IDLE, TX_TOKEN, TX_DATA, TX_HS, TX_WAIT, RX_WAIT, DONE} state_t;
  typedef enum logic [1:0] {AFT_DATA, AFT_RX, AFT_DONE, AFT_RETRY} after_t;

  state_t             r_state;
  after_t             r_after;
  logic               r_read;
  logic [6:0]         r_addr;
  logic [3:0]         r_endp;
  logic [63:0]        r_wdata;
  logic               r_hs_nak;
  logic [RETRY_W-1:0] r_retry;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_ok;
  logic [63:0]        r_rdata;
  logic [98:0]        r_pkt;
  logic               r_pkt_avail;
  logic               r_re;

  logic w_tx_go, w_wait_go, w_timeout, w_last_try;
  logic w_rx, w_rx_ack, w_rx_bad, w_rx_data, w_retry, w_finish;
  logic w_unused;

  assign w_tx_go    = encoder_ready && !nrzi_avail;
  // The minimum gap after a strobe gives the encoder time to drop its ready flag.
  assign w_wait_go  = (r_state == TX_WAIT) && (r_hold == 2'd2) && w_tx_go;
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_last_try = (r_retry == RETRY_W'(MAX_RETRY));
  assign w_rx       = (r_state == RX_WAIT) && pkt_out_avail;
  assign w_rx_ack   = w_rx && !r_read && (pkt_out[98:91] == PID_ACK);
  assign w_rx_bad   = w_rx && r_read && !data_good;
  assign w_rx_data  = w_rx && r_read && data_good && (pkt_out[98:91] == PID_DATA0);
  assign w_retry    = ((r_state == RX_WAIT) && (pkt_out_avail || w_timeout) &&
                       !w_rx_ack && !w_rx_bad && !w_rx_data) ||
                      (w_wait_go && (r_after == AFT_RETRY));
  assign w_finish   = w_rx_ack || (w_wait_go && (r_after == AFT_DONE));
  assign w_unused   = ^{pkt_out[90:80], pkt_out[15:0]};

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state     <= IDLE;
      r_after     <= AFT_DATA;
      r_read      <= 1'b0;
      r_addr      <= '0;
      r_endp      <= '0;
      r_wdata     <= '0;
      r_hs_nak    <= 1'b0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_rdata     <= '0;
      r_pkt       <= '0;
      r_pkt_avail <= 1'b0;
      r_re        <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; later assignments in this block win.
      r_pkt_avail <= 1'b0;
      r_done      <= 1'b0;
      r_re        <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (txn_start) begin
            r_read  <= txn_read;
            r_addr  <= txn_addr;
            r_endp  <= txn_endp;
            r_wdata <= txn_wdata;
            r_retry <= RETRY_W'(1);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_ok    <= 1'b0;
            r_state <= TX_TOKEN;
          end
        end
        TX_TOKEN: if (w_tx_go) begin
          r_pkt       <= {(r_read ? PID_IN : PID_OUT), r_addr, r_endp, 80'd0};
          r_after     <= r_read ? AFT_RX : AFT_DATA;
          r_pkt_avail <= 1'b1;
          r_hold      <= '0;
          r_state     <= TX_WAIT;
        end
        TX_DATA: if (w_tx_go) begin
          r_pkt       <= {PID_DATA0, 11'd0, r_wdata, 16'd0};
          r_after     <= AFT_RX;
          r_pkt_avail <= 1'b1;
          r_hold      <= '0;
          r_state     <= TX_WAIT;
        end
        TX_HS: if (w_tx_go) begin
          r_pkt       <= {(r_hs_nak ? PID_NAK : PID_ACK), 91'd0};
          r_after     <= r_hs_nak ? AFT_RETRY : AFT_DONE;
          r_pkt_avail <= 1'b1;
          r_hold      <= '0;
          r_state     <= TX_WAIT;
        end
        TX_WAIT: begin
          if (r_hold != 2'd2) r_hold <= r_hold + 2'd1;
          if (w_wait_go) begin
            if (r_after == AFT_DATA) begin
              r_state <= TX_DATA;
            end else if ((r_after == AFT_RX) && decoder_ready) begin
              r_state <= RX_WAIT;
              r_re    <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        RX_WAIT: begin
          if (w_rx_bad || w_rx_data) begin
            r_hs_nak <= w_rx_bad;
            r_state  <= TX_HS;
          end else if (!pkt_out_avail && !w_timeout) begin
            r_re  <= 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_rx_data) r_rdata <= pkt_out[79:16];
        end
        default: r_state <= IDLE;
      endcase

      if (w_finish) begin
        r_state <= DONE;
        r_done  <= 1'b1;
        r_ok    <= 1'b1;
        r_busy  <= 1'b0;
      end
      if (w_retry) begin
        if (w_last_try) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_ok    <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_retry <= r_retry + 1'b1;
          r_cnt   <= '0;
          r_state <= TX_TOKEN;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign txn_done     = r_done;
  assign txn_ok       = r_ok;
  assign txn_rdata    = r_rdata;
  assign pkt_in       = r_pkt;
  assign pkt_in_avail = r_pkt_avail;
  assign re           = r_re;
endmodule

// File: tb/tb_usb_host_protocol_fsm.sv
// Self-checking bench: a scripted device answers each receive window from a per-attempt
// plan, and a transaction-level model predicts the packet stream, windows and result.
module tb_usb_host_protocol_fsm;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;
  localparam int CNT_W     = 5;

  localparam logic [7:0] P_OUT = 8'hE1, P_IN = 8'h69, P_DATA0 = 8'hC3, P_ACK = 8'hD2, P_NAK = 8'h5A;

  typedef enum int {R_SILENT, R_ACK, R_NAK, R_OTHER, R_GOOD, R_BAD} resp_e;

  logic        clk = 1'b0;
  logic        rst_b, txn_start, txn_read;
  logic [6:0]  txn_addr;
  logic [3:0]  txn_endp;
  logic [63:0] txn_wdata, txn_rdata;
  logic        busy, txn_done, txn_ok, pkt_in_avail, re;
  logic [98:0] pkt_in, pkt_out;
  logic        encoder_ready, nrzi_avail, pkt_out_avail, data_good, decoder_ready;

  always #5 clk = ~clk;

  usb_host_protocol_fsm #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_b(rst_b), .txn_start(txn_start), .txn_read(txn_read),
    .txn_addr(txn_addr), .txn_endp(txn_endp), .txn_wdata(txn_wdata),
    .busy(busy), .txn_done(txn_done), .txn_ok(txn_ok), .txn_rdata(txn_rdata),
    .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail), .encoder_ready(encoder_ready),
    .nrzi_avail(nrzi_avail), .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail),
    .data_good(data_good), .decoder_ready(decoder_ready), .re(re)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [98:0] act, input logic [98:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [98:0] mk_pkt(input logic [7:0] pid, input logic [6:0] a,
                                         input logic [3:0] e, input logic [63:0] d);
    return {pid, a, e, d, 16'h0000};
  endfunction

  // Device plan: one entry per attempt, i.e. per receive window.
  resp_e       plan_kind [MAX_RETRY];
  int          plan_delay[MAX_RETRY];
  logic [63:0] plan_data [MAX_RETRY];

  // Model state.
  logic [98:0] exp_pkts[$];
  int          exp_win[$];
  logic [98:0] strobe_log[$];
  int          win_log[$];
  bit          m_outstanding = 1'b0;
  bit          m_ok = 1'b0;
  logic [63:0] m_rdata = '0;
  logic [98:0] m_last_pkt = '0;
  bit          last_done_ok = 1'b0;
  int          re_run = 0;
  int          cyc_since = 100;
  bit          chk_en = 1'b0;
  bit          env_en = 1'b0;
  int          win_idx = 0;
  int          cur_w = 0;
  int          rx_cnt = 0;

  task automatic model_reset();
    exp_pkts.delete();
    exp_win.delete();
    m_outstanding = 1'b0;
    m_rdata       = '0;
    m_last_pkt    = '0;
    re_run        = 0;
    cyc_since     = 100;
  endtask

  // Expected outcome of one transaction, computed from the plan attempt by attempt.
  task automatic model_setup(input bit rd, input logic [6:0] a, input logic [3:0] e,
                             input logic [63:0] wd);
    exp_pkts.delete();
    exp_win.delete();
    strobe_log.delete();
    win_log.delete();
    m_ok = 1'b0;
    for (int k = 0; k < MAX_RETRY; k++) begin
      exp_pkts.push_back(mk_pkt(rd ? P_IN : P_OUT, a, e, 64'd0));
      if (!rd) exp_pkts.push_back(mk_pkt(P_DATA0, 7'd0, 4'd0, wd));
      exp_win.push_back(plan_kind[k] == R_SILENT ? TIMEOUT : plan_delay[k]);
      if (!rd && plan_kind[k] == R_ACK) begin
        m_ok = 1'b1;
        break;
      end
      if (rd && plan_kind[k] == R_GOOD) begin
        exp_pkts.push_back(mk_pkt(P_ACK, 7'd0, 4'd0, 64'd0));
        m_rdata = plan_data[k];
        m_ok = 1'b1;
        break;
      end
      if (rd && plan_kind[k] == R_BAD) exp_pkts.push_back(mk_pkt(P_NAK, 7'd0, 4'd0, 64'd0));
    end
    win_idx       = 0;
    m_outstanding = 1'b1;
  endtask

  // Device and bus environment, driven on the falling edge.
  always @(negedge clk) begin
    pkt_out_avail = 1'b0;
    data_good     = 1'b0;
    pkt_out       = '0;
    if (!env_en) begin
      encoder_ready = 1'b0;
      nrzi_avail    = 1'b0;
      decoder_ready = 1'b0;
    end else begin
      encoder_ready = ($urandom_range(0, 3) != 0);
      nrzi_avail    = ($urandom_range(0, 3) == 0);
      decoder_ready = ($urandom_range(0, 3) != 0);
      if (re) begin
        rx_cnt++;
        if (rx_cnt == 1) begin
          cur_w = win_idx;
          win_idx++;
        end
        if (cur_w < MAX_RETRY && plan_kind[cur_w] != R_SILENT && rx_cnt == plan_delay[cur_w]) begin
          pkt_out_avail = 1'b1;
          data_good     = (plan_kind[cur_w] != R_BAD);
          case (plan_kind[cur_w])
            R_ACK:   pkt_out = mk_pkt(P_ACK, 7'd0, 4'd0, 64'd0);
            R_NAK:   pkt_out = mk_pkt(P_NAK, 7'd0, 4'd0, 64'd0);
            default: pkt_out = mk_pkt(P_DATA0, 7'd0, 4'd0, plan_data[cur_w]);
          endcase
        end
      end else begin
        rx_cnt = 0;
        if ($urandom_range(0, 7) == 0) begin
          pkt_out_avail = 1'b1;
          data_good     = 1'b1;
          pkt_out = $urandom_range(0, 1) ? mk_pkt(P_ACK, 7'd0, 4'd0, 64'd0)
                                         : mk_pkt(P_DATA0, 7'd0, 4'd0, {$urandom, $urandom});
        end
      end
    end
  end

  // Compare process: checks outputs 2 time units after every rising edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (pkt_in_avail) begin
        check("strobe_gate", encoder_ready && !nrzi_avail, 1'b1);
        check("strobe_spacing", cyc_since >= 3, 1'b1);
        strobe_log.push_back(pkt_in);
        check("pkt_in_expected", exp_pkts.size() != 0, 1'b1);
        if (exp_pkts.size() != 0) begin
          m_last_pkt = exp_pkts.pop_front();
          check("pkt_in", pkt_in, m_last_pkt);
        end else begin
          m_last_pkt = pkt_in;
        end
        cyc_since = 0;
      end else begin
        check("pkt_in_hold", pkt_in, m_last_pkt);
        cyc_since++;
      end

      if (re) begin
        if (re_run == 0) begin
          check("re_decoder_gate", decoder_ready, 1'b1);
          check("re_after_strobe", cyc_since >= 2, 1'b1);
        end
        re_run++;
      end else if (re_run != 0) begin
        win_log.push_back(re_run);
        check("re_window_expected", exp_win.size() != 0, 1'b1);
        if (exp_win.size() != 0) check("re_len", 99'(re_run), 99'(exp_win.pop_front()));
        re_run = 0;
      end

      if (txn_done) begin
        check("done_expected", m_outstanding, 1'b1);
        check("done_busy", busy, 1'b0);
        check("txn_ok", txn_ok, m_ok);
        check("txn_rdata", txn_rdata, m_rdata);
        check("pkts_left", 99'(exp_pkts.size()), 99'd0);
        check("windows_left", 99'(exp_win.size()), 99'd0);
        last_done_ok  = txn_ok;
        m_outstanding = 1'b0;
      end else if (m_outstanding) begin
        check("busy", busy, 1'b1);
      end else begin
        check("idle_busy", busy, 1'b0);
        check("idle_re", re, 1'b0);
        check("idle_pkt_avail", pkt_in_avail, 1'b0);
        check("idle_rdata", txn_rdata, m_rdata);
      end
    end
  end

  task automatic clear_plan();
    for (int k = 0; k < MAX_RETRY; k++) begin
      plan_kind[k]  = R_SILENT;
      plan_delay[k] = 1;
      plan_data[k]  = '0;
    end
  endtask

  bit aborted = 1'b0;

  task automatic run_txn(input bit rd, input logic [6:0] a, input logic [3:0] e, input logic [63:0] wd);
    int budget;
    @(negedge clk);
    txn_read  = rd;
    txn_addr  = a;
    txn_endp  = e;
    txn_wdata = wd;
    txn_start = 1'b1;
    model_setup(rd, a, e, wd);
    @(negedge clk);
    txn_start = 1'b0;
    budget = 0;
    while (!txn_done && budget < 3000) begin
      if (busy && $urandom_range(0, 15) == 0) begin
        txn_start = 1'b1;
        txn_read  = $urandom_range(0, 1);
        txn_addr  = 7'($urandom);
        txn_endp  = 4'($urandom);
        txn_wdata = {$urandom, $urandom};
      end else begin
        txn_start = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    txn_start = 1'b0;
    if (!txn_done) begin
      check("txn_done_within_budget", txn_done, 1'b1);
      aborted = 1'b1;
    end
  endtask

  initial begin
    int budget;
    rst_b = 1'b1; txn_start = 1'b0; txn_read = 1'b0;
    txn_addr = '0; txn_endp = '0; txn_wdata = '0;
    clear_plan();
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", txn_done, 1'b0);
    check("rst_ok", txn_ok, 1'b0);
    check("rst_rdata", txn_rdata, 99'd0);
    check("rst_pkt_in", pkt_in, 99'd0);
    check("rst_pkt_avail", pkt_in_avail, 1'b0);
    check("rst_re", re, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    model_reset();
    env_en = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    // OUT, device ACKs.
    clear_plan();
    plan_kind[0] = R_ACK; plan_delay[0] = 3;
    run_txn(1'b0, 7'h05, 4'h1, 64'h0123456789ABCDEF);
    check("t1_npkts", 99'(strobe_log.size()), 99'd2);
    check("t1_tok_pid", strobe_log[0][98:91], 8'hE1);
    check("t1_tok_addr", strobe_log[0][90:84], 7'h05);
    check("t1_tok_endp", strobe_log[0][83:80], 4'h1);
    check("t1_data_pid", strobe_log[1][98:91], 8'hC3);
    check("t1_data", strobe_log[1][79:16], 64'h0123456789ABCDEF);
    check("t1_ok", last_done_ok, 1'b1);

    // OUT, ACK arrives on the very cycle the timeout is reached.
    clear_plan();
    plan_kind[0] = R_ACK; plan_delay[0] = TIMEOUT;
    run_txn(1'b0, 7'h11, 4'h2, 64'h55AA55AA55AA55AA);
    check("t1b_ok", last_done_ok, 1'b1);
    check("t1b_win", 99'(win_log[0]), 99'd16);

    // IN, good DATA0.
    clear_plan();
    plan_kind[0] = R_GOOD; plan_delay[0] = 5; plan_data[0] = 64'hDEADBEEFCAFEF00D;
    run_txn(1'b1, 7'h7F, 4'hF, 64'd0);
    check("t2_npkts", 99'(strobe_log.size()), 99'd2);
    check("t2_tok_pid", strobe_log[0][98:91], 8'h69);
    check("t2_tok_addr", strobe_log[0][90:84], 7'h7F);
    check("t2_tok_endp", strobe_log[0][83:80], 4'hF);
    check("t2_ack_pid", strobe_log[1][98:91], 8'hD2);
    check("t2_rdata", txn_rdata, 64'hDEADBEEFCAFEF00D);
    check("t2_ok", last_done_ok, 1'b1);

    // IN, corrupted first response, good second.
    clear_plan();
    plan_kind[0] = R_BAD;  plan_delay[0] = 4; plan_data[0] = 64'h1111111111111111;
    plan_kind[1] = R_GOOD; plan_delay[1] = 2; plan_data[1] = 64'h0F1E2D3C4B5A6978;
    run_txn(1'b1, 7'h22, 4'h3, 64'd0);
    check("t3_npkts", 99'(strobe_log.size()), 99'd4);
    check("t3_pid0", strobe_log[0][98:91], 8'h69);
    check("t3_pid1", strobe_log[1][98:91], 8'h5A);
    check("t3_pid2", strobe_log[2][98:91], 8'h69);
    check("t3_pid3", strobe_log[3][98:91], 8'hD2);
    check("t3_attempts", 99'(win_log.size()), 99'd2);
    check("t3_ok", last_done_ok, 1'b1);

    // OUT, device silent: all attempts time out.
    clear_plan();
    run_txn(1'b0, 7'h33, 4'h4, 64'hFEDCBA9876543210);
    check("t4_npkts", 99'(strobe_log.size()), 99'd6);
    check("t4_nwin", 99'(win_log.size()), 99'd3);
    check("t4_win0", 99'(win_log[0]), 99'd16);
    check("t4_win2", 99'(win_log[2]), 99'd16);
    check("t4_ok", last_done_ok, 1'b0);
    check("t4_rdata", txn_rdata, 64'h0F1E2D3C4B5A6978);

    // Idle with noise on the decoded-packet strobe.
    repeat (30) @(negedge clk);

    // Reset while waiting for a response.
    clear_plan();
    @(negedge clk);
    txn_read = 1'b0; txn_addr = 7'h44; txn_endp = 4'h5; txn_wdata = 64'h1234;
    txn_start = 1'b1;
    model_setup(1'b0, 7'h44, 4'h5, 64'h1234);
    @(negedge clk);
    txn_start = 1'b0;
    budget = 0;
    while (!re && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("t6_reached_rx", re, 1'b1);
    rst_b  = 1'b1;
    chk_en = 1'b0;
    @(posedge clk); #2;
    check("t6_busy", busy, 1'b0);
    check("t6_re", re, 1'b0);
    check("t6_done", txn_done, 1'b0);
    check("t6_pkt_avail", pkt_in_avail, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    clear_plan();
    plan_kind[0] = R_ACK; plan_delay[0] = 1;
    run_txn(1'b0, 7'h45, 4'h6, 64'hA5A5);
    check("t6_new_ok", last_done_ok, 1'b1);

    // Randomized transactions.
    for (int t = 0; t < 40 && !aborted; t++) begin
      bit rd;
      rd = $urandom_range(0, 1);
      for (int k = 0; k < MAX_RETRY; k++) begin
        case ($urandom_range(0, 3))
          0:       plan_kind[k] = rd ? R_GOOD : R_ACK;
          1:       plan_kind[k] = rd ? R_BAD  : R_OTHER;
          2:       plan_kind[k] = R_NAK;
          default: plan_kind[k] = R_SILENT;
        endcase
        plan_delay[k] = $urandom_range(1, TIMEOUT);
        plan_data[k]  = {$urandom, $urandom};
      end
      run_txn(rd, 7'($urandom), 4'($urandom), {$urandom, $urandom});
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
